// File: rtl/fp_issue_ctrl_if.sv
// Handshake and FP-unit bus for fp_issue_ctrl.
// The master drives operands, FP results and consumer ready; the slave is the controller.
interface fp_issue_ctrl_if #(
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_a;
   logic [31:0]      in_b;
   logic [TAG_W-1:0] in_tag;
   logic [31:0]      fu_dataa;
   logic [31:0]      fu_datab;
   logic [31:0]      fu_result;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_result;
   logic [TAG_W-1:0] out_tag;
   logic             busy;

   modport master (
      output in_valid, in_a, in_b, in_tag, fu_result, out_ready,
      input  in_ready, fu_dataa, fu_datab, out_valid, out_result, out_tag, busy
   );

   modport slave (
      input  in_valid, in_a, in_b, in_tag, fu_result, out_ready,
      output in_ready, fu_dataa, fu_datab, out_valid, out_result, out_tag, busy
   );
endinterface

// File: rtl/fp_issue_ctrl.sv
// Issue/collect controller for a fixed-latency, non-stallable FP unit.
// Result slots are reserved on issue, so output backpressure can never drop a result.
module fp_issue_ctrl #(
   parameter int LATENCY = 10,
   parameter int DEPTH   = 16,
   parameter int TAG_W   = 4
) (
   input logic           clk,
   input logic           rst_n,
   fp_issue_ctrl_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [31:0]      result;
      logic [TAG_W-1:0] tag;
   } entry_t;

   logic [LATENCY-1:0] r_vld_pipe;
   logic [TAG_W-1:0]   r_tag_pipe [LATENCY];
   logic [31:0]        r_dataa;
   logic [31:0]        r_datab;
   entry_t             r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic [CNT_W-1:0]   r_reserved;

   logic   w_in_ready;
   logic   w_accept;
   logic   w_pop;
   logic   w_fifo_wr;
   logic   w_out_valid;
   entry_t w_head;

   // Ready depends only on registered credits (and is held low while in reset).
   assign w_in_ready  = rst_n && (r_reserved < CNT_W'(DEPTH));
   assign w_out_valid = (r_count != '0);
   assign w_accept    = bus.in_valid && w_in_ready;
   assign w_pop       = w_out_valid && bus.out_ready;
   assign w_fifo_wr   = r_vld_pipe[LATENCY-1];
   assign w_head      = w_out_valid ? r_mem[r_rd_ptr] : '0;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vld_pipe <= '0;
         for (int i = 0; i < LATENCY; i++) r_tag_pipe[i] <= '0;
         r_dataa <= '0;
         r_datab <= '0;
      end else begin
         r_vld_pipe[0] <= w_accept;
         r_tag_pipe[0] <= bus.in_tag;
         for (int i = 1; i < LATENCY; i++) begin
            r_vld_pipe[i] <= r_vld_pipe[i-1];
            r_tag_pipe[i] <= r_tag_pipe[i-1];
         end
         if (w_accept) begin
            r_dataa <= bus.in_a;
            r_datab <= bus.in_b;
         end
      end
   end

   // NOTE: storage is not reset; the head is forced to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (rst_n && w_fifo_wr) r_mem[r_wr_ptr] <= '{result: bus.fu_result, tag: r_tag_pipe[LATENCY-1]};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_reserved <= '0;
      end else begin
         if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_fifo_wr, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         // A credit is held from accept until the matching result is popped.
         case ({w_accept, w_pop})
            2'b10:   r_reserved <= r_reserved + CNT_W'(1);
            2'b01:   r_reserved <= r_reserved - CNT_W'(1);
            default: r_reserved <= r_reserved;
         endcase
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.fu_dataa   = r_dataa;
   assign bus.fu_datab   = r_datab;
   assign bus.out_valid  = w_out_valid;
   assign bus.out_result = w_head.result;
   assign bus.out_tag    = w_head.tag;
   assign bus.busy       = (r_reserved != '0);
endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Directed bench for fp_issue_ctrl with a pipelined single-precision adder model
// and a result/tag scoreboard filled on accept and drained on pop.
module tb_fp_issue_ctrl;
   localparam int LATENCY = 10;
   localparam int DEPTH   = 16;
   localparam int TAG_W   = 4;
   localparam int CNT_W   = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   logic rst_n;

   fp_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

   fp_issue_ctrl #(.LATENCY(LATENCY), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_acc    = 0;
   int n_pop    = 0;
   int first_pop;
   int last_pop;
   logic [31+TAG_W:0] sb [$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Exact for normal operands whose exponents differ by only a few steps.
   function automatic real sp2real(input logic [31:0] a);
      if (a[30:0] == 31'd0) return 0.0;
      return $bitstoreal({a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'd0});
   endfunction

   function automatic logic [31:0] real2sp(input real r);
      logic [63:0] d;
      logic [30:0] mag;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return {d[63], 31'd0};
      mag = {8'(d[62:52] - 11'd896), d[51:29]};
      if (d[28] && ((d[27:0] != 28'd0) || d[29])) mag = mag + 31'd1;
      return {d[63], mag};
   endfunction

   function automatic logic [31:0] f_add(input logic [31:0] a, input logic [31:0] b);
      return real2sp(sp2real(a) + sp2real(b));
   endfunction

   function automatic logic [31:0] rand_fp();
      return {1'b0, 8'(127 + $urandom_range(0, 3)), 23'($urandom)};
   endfunction

   // FP unit model: result of the operands launched at edge E is visible at edge E+LATENCY.
   logic [31:0] r_fu_pipe [LATENCY-1];
   always @(posedge clk) begin
      r_fu_pipe[0] <= f_add(bus.fu_dataa, bus.fu_datab);
      for (int i = 1; i < LATENCY - 1; i++) r_fu_pipe[i] <= r_fu_pipe[i-1];
   end
   assign bus.fu_result = r_fu_pipe[LATENCY-2];

   always @(negedge clk) begin
      if (rst_n) check("fifo_no_overflow", 64'(dut.w_fifo_wr && (dut.r_count == CNT_W'(DEPTH))), 64'(0));
   end

   task automatic drive_rand(input logic valid);
      bus.in_valid = valid;
      bus.in_a     = rand_fp();
      bus.in_b     = rand_fp();
      bus.in_tag   = TAG_W'($urandom);
   endtask

   // Called just after a posedge; scores the upcoming edge and returns just after it.
   task automatic cycle();
      logic acc;
      logic pop;
      logic [31+TAG_W:0] exp;
      #1;
      acc = bus.in_valid && bus.in_ready;
      pop = bus.out_valid && bus.out_ready;
      if (!rst_n) begin
         sb.delete();
      end else begin
         if (pop) begin
            check("pop_has_expected", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
               exp = sb.pop_front();
               check("result_order", 64'({bus.out_result, bus.out_tag}), 64'(exp));
            end
            n_pop++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
         end
         if (acc) begin
            sb.push_back({f_add(bus.in_a, bus.in_b), bus.in_tag});
            n_acc++;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic drain(input string tag);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 300 && (sb.size() != 0 || bus.busy); k++) cycle();
      check({tag, "_drained"}, 64'(sb.size()), 64'(0));
      check({tag, "_idle"}, 64'(bus.busy), 64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_acc;
      int base_pop;
      logic [31+TAG_W:0] head;

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b0;
      first_pop     = -1;
      last_pop      = -1;
      @(posedge clk);
      #1;
      check("reset_in_ready", 64'(bus.in_ready), 64'(0));
      check("reset_out_valid", 64'(bus.out_valid), 64'(0));
      check("reset_out_result", 64'(bus.out_result), 64'(0));
      check("reset_out_tag", 64'(bus.out_tag), 64'(0));
      check("reset_busy", 64'(bus.busy), 64'(0));
      check("reset_fu_dataa", 64'(bus.fu_dataa), 64'(0));
      rst_n = 1'b1;
      #1;
      check("post_reset_in_ready", 64'(bus.in_ready), 64'(1));

      // Single op: 1.0 + 2.0, tag 3.
      bus.in_valid = 1'b1;
      bus.in_a     = 32'h3F80_0000;
      bus.in_b     = 32'h4000_0000;
      bus.in_tag   = TAG_W'(3);
      cycle();
      bus.in_valid = 1'b0;
      for (int k = 1; k < LATENCY; k++) begin
         cycle();
         check("single_not_yet_valid", 64'(bus.out_valid), 64'(0));
      end
      cycle();
      check("single_valid", 64'(bus.out_valid), 64'(1));
      check("single_result", 64'(bus.out_result), 64'(32'h4040_0000));
      check("single_tag", 64'(bus.out_tag), 64'(3));
      check("single_busy", 64'(bus.busy), 64'(1));
      bus.out_ready = 1'b1;
      cycle();
      check("single_busy_after_pop", 64'(bus.busy), 64'(0));
      check("single_empty_after_pop", 64'(bus.out_valid), 64'(0));

      // Streaming: 40 back-to-back ops with the consumer always ready.
      first_pop = -1;
      base_pop  = n_pop;
      for (int i = 0; i < 40; i++) begin
         drive_rand(1'b1);
         check("stream_in_ready", 64'(bus.in_ready), 64'(1));
         cycle();
      end
      drain("stream");
      check("stream_pops", 64'(n_pop - base_pop), 64'(40));
      check("stream_back_to_back", 64'(last_pop - first_pop), 64'(39));

      // Backpressure: fill every credit, hold the head, then release one slot.
      bus.out_ready = 1'b0;
      base_acc      = n_acc;
      for (int i = 0; i < 30; i++) begin
         drive_rand(1'b1);
         cycle();
      end
      check("bp_accepts", 64'(n_acc - base_acc), 64'(DEPTH));
      check("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
      check("bp_out_valid", 64'(bus.out_valid), 64'(1));
      head = {bus.out_result, bus.out_tag};
      for (int i = 0; i < 3; i++) begin
         drive_rand(1'b1);
         cycle();
         check("bp_head_stable", 64'({bus.out_result, bus.out_tag}), 64'(head));
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      cycle();
      check("bp_resume_after_pop", 64'(bus.in_ready), 64'(1));
      drive_rand(1'b1);
      cycle();
      check("full_boundary_ready", 64'(bus.in_ready), 64'(1));
      bus.out_ready = 1'b0;
      base_acc      = n_acc;
      for (int i = 0; i < 4; i++) begin
         drive_rand(1'b1);
         cycle();
      end
      check("full_boundary_one_slot", 64'(n_acc - base_acc), 64'(1));
      check("full_again_in_ready", 64'(bus.in_ready), 64'(0));
      drain("bp");

      // Reset mid-flight: 3 buffered results plus 5 ops still in the unit.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_rand(1'b1);
         cycle();
      end
      bus.in_valid = 1'b0;
      for (int i = 0; i < LATENCY; i++) cycle();
      check("rst_buffered_valid", 64'(bus.out_valid), 64'(1));
      for (int i = 0; i < 5; i++) begin
         drive_rand(1'b1);
         cycle();
      end
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      cycle();
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_busy", 64'(bus.busy), 64'(0));
      check("rst_in_ready", 64'(bus.in_ready), 64'(0));
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cycle();
         check("rst_no_stale", 64'(bus.out_valid), 64'(0));
      end

      // Wrap-around: 3*DEPTH ops with random stalls on both sides.
      base_acc = n_acc;
      base_pop = n_pop;
      for (int k = 0; k < 3000 && (n_acc - base_acc) < 3 * DEPTH; k++) begin
         drive_rand(1'($urandom_range(0, 3) != 0));
         bus.out_ready = 1'($urandom_range(0, 1));
         cycle();
      end
      check("wrap_accepts", 64'(n_acc - base_acc), 64'(3 * DEPTH));
      drain("wrap");
      check("wrap_pops", 64'(n_pop - base_pop), 64'(3 * DEPTH));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/fp_issue_ctrl.md
# fp_issue_ctrl

Issue/collect controller for the fixed-latency, non-stallable floating-point units (e.g. fp_add). It accepts operand pairs over a valid/ready handshake, drives them into the unit, tracks each operation through the unit's pipeline, and buffers results in a FIFO. Results leave over a valid/ready handshake. Credit accounting guarantees a result slot is reserved before any operation issues, so no result is ever dropped under output backpressure.

## Interface
Parameters:
- LATENCY, 10, edges from the edge that launches operands on fu_dataa/fu_datab to the edge where fu_result holds that operation's result; ≥1
- DEPTH, 16, result FIFO entries; power of two, ≥2; DEPTH ≥ LATENCY+1 required for 1 op/cycle
- TAG_W, 4, width of the user tag carried alongside each operation

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair
- in_a  in  32  operand A (IEEE-754 single)
- in_b  in  32  operand B
- in_tag  in  TAG_W  user tag, returned with result
- fu_dataa  out  32  operand A to FP unit (registered)
- fu_datab  out  32  operand B to FP unit (registered)
- fu_result  in  32  FP unit result
- out_valid  out  1  result available at FIFO head
- out_ready  in  1  consumer accepts result
- out_result  out  32  result at FIFO head
- out_tag  out  TAG_W  tag at FIFO head
- busy  out  1  any operation in flight or buffered

## Operation
- Issue: accept on an edge where in_valid && in_ready. At that edge, fu_dataa/fu_datab ← in_a/in_b; vld_pipe[0] ← 1; tag_pipe[0] ← in_tag. On non-accept edges fu_dataa/fu_datab hold their value; vld_pipe[0] ← 0.
- Tracking: vld_pipe/tag_pipe are LATENCY-deep shift registers advancing every edge unconditionally, since the unit never stalls.
- Capture: on the edge where vld_pipe[LATENCY-1] is 1, {fu_result, tag_pipe[LATENCY-1]} is written to the FIFO tail. fu_result is ignored on all other edges.
- Credits: `reserved` counter, 0..DEPTH, counts in-flight plus buffered entries.
  - +1 on accept; −1 on pop (out_valid && out_ready); unchanged when both occur on the same edge.
  - in_ready = (reserved < DEPTH). It is a function of registered state only and has no combinational path from out_ready or in_valid.
- Output: out_valid = FIFO non-empty. out_result/out_tag show the head entry and stay stable while out_valid && !out_ready. A pop advances the head.
- FIFO pointers wrap modulo DEPTH. The FIFO write and pop are independent on the same edge. A write into an empty FIFO is not bypassed to the output.
- Ordering: results emerge in issue order with their own tags.
- busy = (reserved != 0).
- FIFO overflow is impossible by construction. Bench asserts write never occurs when FIFO is full.

## Timing
- Reset (rst_n=0 at an edge): reserved=0, vld_pipe=0, tag_pipe=0, FIFO pointers/count=0, fu_dataa=fu_datab=0. Resulting outputs: in_ready=0 during the reset cycle, out_valid=0, out_result=0, out_tag=0, busy=0. in_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation: all in-flight and buffered results are discarded. fu_result values arriving afterward are ignored because vld_pipe is cleared.
- Latency: accept at edge E → FIFO write at edge E+LATENCY → out_valid high from the cycle after E+LATENCY. Earliest pop is at edge E+LATENCY+1.
- Throughput: 1 op/cycle sustained when out_ready=1 and DEPTH ≥ LATENCY+1.
- Full: with reserved=DEPTH, in_ready=0. A pop at edge P makes in_ready=1 in the cycle after P.
- Simultaneous accept and pop at reserved=DEPTH cannot occur because in_ready=0. At reserved=DEPTH−1, both are allowed and reserved stays DEPTH−1.

## Test plan
The bench models the FP unit as a LATENCY-stage pipeline of an exact single-precision adder.
- Single op: in_a=0x3F800000, in_b=0x40000000, tag=3, accepted at edge 0 → out_valid rises after edge 10; out_result=0x40400000, out_tag=3; busy low after the pop.
- Streaming: 40 random pairs back-to-back with out_ready=1 → in_ready never drops, all 40 results emerge in order with matching tags, one per cycle.
- Backpressure: out_ready=0, in_valid=1 continuously → exactly 16 accepts, then in_ready=0. Head stays stable. Raise out_ready → all 16 results drain in order and accepts resume one cycle after the first pop.
- Full boundary: reserved=15 with an accept and a pop on the same edge → reserved stays 15 and in_ready stays 1.
- Reset mid-flight: 5 ops in pipeline plus 3 buffered, then rst_n=0 for one edge → out_valid=0, busy=0. No stale result appears in the following 20 cycles.
- Wrap-around: 3×DEPTH ops with random out_ready → no loss or duplication, pointers wrap correctly.
